// File: rtl/cpu_axi_bridge_if.sv
// rtl/cpu_axi_bridge_if.sv - AXI3 bus bundle between the CPU bridge (master) and the interconnect (slave)
interface cpu_axi_bridge_if;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;

  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [3:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [1:0]  awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;

  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;

  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/cpu_axi_bridge.sv
// rtl/cpu_axi_bridge.sv - merges the CPU instruction and data SRAM ports into one single-outstanding AXI3 master
module cpu_axi_bridge #(
  parameter logic [3:0] INST_ID = 4'd0,
  parameter logic [3:0] DATA_ID = 4'd1
) (
  input  logic             clk,
  input  logic             resetn,

  input  logic             inst_sram_en,
  input  logic [31:0]      inst_sram_addr,
  output logic [31:0]      inst_sram_rdata,
  output logic             inst_stall,

  input  logic             data_sram_en,
  input  logic [3:0]       data_sram_wen,
  input  logic [31:0]      data_sram_addr,
  input  logic [31:0]      data_sram_wdata,
  output logic [31:0]      data_sram_rdata,
  output logic             data_stall,

  cpu_axi_bridge_if.master axi
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_REQ  = 3'd3,
    WR_RESP = 3'd4,
    DONE    = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic        src_data_q;
  logic [31:0] addr_q;
  logic [3:0]  wen_q;
  logic [31:0] wdata_q;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic [31:0] inst_rdata_q;
  logic [31:0] data_rdata_q;
  logic        aw_hs, w_hs;
  logic        start;
  logic        unused_resp;

  assign aw_hs = axi.awvalid & axi.awready;
  assign w_hs  = axi.wvalid & axi.wready;
  assign start = (state_q == IDLE) & (data_sram_en | inst_sram_en);

  // Response status and IDs are not checked; one transaction is ever in flight.
  assign unused_resp = ^{axi.rid, axi.rresp, axi.rlast, axi.bid, axi.bresp};

  always_comb begin
    state_d   = state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    unique case (state_q)
      IDLE: begin
        if (data_sram_en) begin
          state_d = (data_sram_wen != 4'd0) ? WR_REQ : RD_ADDR;
        end else if (inst_sram_en) begin
          state_d = RD_ADDR;
        end
      end
      RD_ADDR: if (axi.arready) state_d = RD_DATA;
      RD_DATA: if (axi.rvalid) state_d = DONE;
      WR_REQ: begin
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q | w_hs;
        if (aw_done_d && w_done_d) begin
          state_d   = WR_RESP;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      WR_RESP: if (axi.bvalid) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      src_data_q   <= 1'b0;
      addr_q       <= 32'd0;
      wen_q        <= 4'd0;
      wdata_q      <= 32'd0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      inst_rdata_q <= 32'd0;
      data_rdata_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      // The request is frozen here; the CPU may change or drop its inputs afterwards.
      if (start) begin
        src_data_q <= data_sram_en;
        addr_q     <= data_sram_en ? data_sram_addr : inst_sram_addr;
        wen_q      <= data_sram_en ? data_sram_wen : 4'd0;
        wdata_q    <= data_sram_wdata;
      end
      if ((state_q == RD_DATA) && axi.rvalid) begin
        if (src_data_q) begin
          data_rdata_q <= axi.rdata;
        end else begin
          inst_rdata_q <= axi.rdata;
        end
      end
    end
  end

  assign axi.arid    = src_data_q ? DATA_ID : INST_ID;
  assign axi.araddr  = addr_q;
  assign axi.arlen   = 4'd0;
  assign axi.arsize  = 3'b010;
  assign axi.arburst = 2'b01;
  assign axi.arlock  = 2'd0;
  assign axi.arcache = 4'd0;
  assign axi.arprot  = 3'd0;
  assign axi.arvalid = (state_q == RD_ADDR);
  assign axi.rready  = (state_q == RD_DATA);

  assign axi.awid    = DATA_ID;
  assign axi.awaddr  = addr_q;
  assign axi.awlen   = 4'd0;
  assign axi.awsize  = 3'b010;
  assign axi.awburst = 2'b01;
  assign axi.awlock  = 2'd0;
  assign axi.awcache = 4'd0;
  assign axi.awprot  = 3'd0;
  assign axi.awvalid = (state_q == WR_REQ) & ~aw_done_q;

  assign axi.wid     = axi.awid;
  assign axi.wdata   = wdata_q;
  assign axi.wstrb   = wen_q;
  assign axi.wlast   = 1'b1;
  assign axi.wvalid  = (state_q == WR_REQ) & ~w_done_q;
  assign axi.bready  = (state_q == WR_RESP);

  assign inst_sram_rdata = inst_rdata_q;
  assign data_sram_rdata = data_rdata_q;

  // A port is released only in the DONE cycle of its own transaction.
  assign inst_stall = inst_sram_en & ~((state_q == DONE) & ~src_data_q);
  assign data_stall = data_sram_en & ~((state_q == DONE) & src_data_q);

endmodule

// File: tb/tb_cpu_axi_bridge.sv
// tb/tb_cpu_axi_bridge.sv - directed scoreboard bench for cpu_axi_bridge with a delay-programmable AXI slave
module tb_cpu_axi_bridge;

  logic        clk;
  logic        resetn;
  logic        inst_en;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata;
  logic        inst_stall;
  logic        data_en;
  logic [3:0]  data_wen;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_stall;

  cpu_axi_bridge_if axi ();

  cpu_axi_bridge #(.INST_ID(4'd0), .DATA_ID(4'd1)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .inst_sram_en    (inst_en),
    .inst_sram_addr  (inst_addr),
    .inst_sram_rdata (inst_rdata),
    .inst_stall      (inst_stall),
    .data_sram_en    (data_en),
    .data_sram_wen   (data_wen),
    .data_sram_addr  (data_addr),
    .data_sram_wdata (data_wdata),
    .data_sram_rdata (data_rdata),
    .data_stall      (data_stall),
    .axi             (axi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    bit          is_data;
    bit          is_write;
    logic [31:0] addr;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];

  // Slave memory: unwritten words read as a fixed function of their address.
  logic [31:0] mem [logic [31:0]];

  function automatic logic [31:0] rd_model(input logic [31:0] a);
    if (a == 32'hBFC0_0000) return 32'h3C08_0001;
    return a ^ 32'h5A5A_5A5A;
  endfunction

  function automatic logic [31:0] peek(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : rd_model(a);
  endfunction

  int ar_delay = 0, r_delay = 0, aw_delay = 0, w_delay = 0, b_delay = 0;
  int ar_wait, r_wait, aw_wait, w_wait, b_wait;
  int ar_count = 0;
  bit hs_ar, hs_r, hs_aw, hs_w, hs_b;
  bit rd_pend, aw_got, w_got, b_pend;
  logic [31:0] cap_araddr, cap_awaddr, cap_wdata;
  logic [3:0]  cap_wstrb, cap_arid;

  // DUT AXI outputs only change at posedge, so the slave decides at negedge and
  // retires at the following negedge whatever handshake it set up.
  always @(negedge clk) begin
    if (!resetn) begin
      hs_ar = 0; hs_r = 0; hs_aw = 0; hs_w = 0; hs_b = 0;
      rd_pend = 0; aw_got = 0; w_got = 0; b_pend = 0;
      ar_wait = 0; r_wait = 0; aw_wait = 0; w_wait = 0; b_wait = 0;
      axi.arready = 0; axi.rvalid = 0; axi.awready = 0; axi.wready = 0; axi.bvalid = 0;
      axi.rid = 0; axi.rdata = 0; axi.rresp = 0; axi.rlast = 1; axi.bid = 0; axi.bresp = 0;
    end else begin
      if (hs_ar) begin
        rd_pend = 1; r_wait = 0; ar_wait = 0; ar_count++;
        axi.rdata = peek(cap_araddr); axi.rid = cap_arid;
      end
      if (hs_r) rd_pend = 0;
      if (hs_aw) begin aw_got = 1; aw_wait = 0; end
      if (hs_w) begin w_got = 1; w_wait = 0; end
      if (aw_got && w_got) begin
        logic [31:0] m;
        m = {{8{cap_wstrb[3]}}, {8{cap_wstrb[2]}}, {8{cap_wstrb[1]}}, {8{cap_wstrb[0]}}};
        mem[cap_awaddr] = (peek(cap_awaddr) & ~m) | (cap_wdata & m);
        aw_got = 0; w_got = 0; b_pend = 1; b_wait = 0;
      end
      if (hs_b) b_pend = 0;

      axi.arready = axi.arvalid && (ar_wait >= ar_delay);
      if (axi.arvalid && !axi.arready) ar_wait++;
      axi.rvalid = rd_pend && (r_wait >= r_delay);
      if (rd_pend && !axi.rvalid) r_wait++;
      axi.awready = axi.awvalid && (aw_wait >= aw_delay);
      if (axi.awvalid && !axi.awready) aw_wait++;
      axi.wready = axi.wvalid && (w_wait >= w_delay);
      if (axi.wvalid && !axi.wready) w_wait++;
      axi.bvalid = b_pend && (b_wait >= b_delay);
      if (b_pend && !axi.bvalid) b_wait++;
      axi.bid = 4'd1;

      hs_ar = axi.arvalid && axi.arready;
      if (hs_ar) begin cap_araddr = axi.araddr; cap_arid = axi.arid; end
      hs_r  = axi.rvalid && axi.rready;
      hs_aw = axi.awvalid && axi.awready;
      if (hs_aw) cap_awaddr = axi.awaddr;
      hs_w  = axi.wvalid && axi.wready;
      if (hs_w) begin cap_wdata = axi.wdata; cap_wstrb = axi.wstrb; end
      hs_b  = axi.bvalid && axi.bready;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_done(input bit is_data, input int max_cycles);
    exp_t e;
    bit ok;
    ok = 0;
    for (int i = 0; i < max_cycles; i++) begin
      if ((is_data ? data_stall : inst_stall) === 1'b0) begin
        ok = 1;
        break;
      end
      tick();
    end
    chk(is_data ? "data_done_in_time" : "inst_done_in_time", {31'd0, ok}, 32'd1);
    if (ok) begin
      chk("sb_not_empty", {31'd0, sb.size() > 0}, 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("sb_port", {31'd0, is_data}, {31'd0, e.is_data});
        if (e.is_write) chk("sb_write_mem", peek(e.addr), e.val);
        else chk(is_data ? "sb_data_rdata" : "sb_inst_rdata", is_data ? data_rdata : inst_rdata, e.val);
      end
    end
  endtask

  task automatic do_read(input bit is_data, input logic [31:0] a, input logic [31:0] v);
    sb.push_back('{is_data, 1'b0, a, v});
    if (is_data) begin data_en = 1; data_wen = 4'd0; data_addr = a; end
    else begin inst_en = 1; inst_addr = a; end
    tick();
    wait_done(is_data, 40);
    inst_en = 0; data_en = 0;
    tick();
  endtask

  task automatic do_write(input logic [31:0] a, input logic [3:0] wen, input logic [31:0] wd,
                          input logic [31:0] v);
    sb.push_back('{1'b1, 1'b1, a, v});
    data_en = 1; data_wen = wen; data_addr = a; data_wdata = wd;
    tick();
    wait_done(1'b1, 40);
    data_en = 0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base_ar, rr, spurious, n_ar, addr_bad, stall_bad;
    resetn = 0; inst_en = 0; inst_addr = 0;
    data_en = 0; data_wen = 0; data_addr = 0; data_wdata = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_arvalid", {31'd0, axi.arvalid}, 32'd0);
    chk("rst_rready", {31'd0, axi.rready}, 32'd0);
    chk("rst_awvalid", {31'd0, axi.awvalid}, 32'd0);
    chk("rst_wvalid", {31'd0, axi.wvalid}, 32'd0);
    chk("rst_bready", {31'd0, axi.bready}, 32'd0);
    chk("rst_inst_rdata", inst_rdata, 32'd0);
    chk("rst_data_rdata", data_rdata, 32'd0);
    chk("rst_inst_stall", {31'd0, inst_stall}, 32'd0);
    chk("rst_data_stall", {31'd0, data_stall}, 32'd0);
    chk("const_ar", {19'd0, axi.arlen, axi.arsize, axi.arburst, axi.arlock, axi.arcache, axi.arprot},
        {19'd0, 4'd0, 3'b010, 2'b01, 2'd0, 4'd0, 3'd0});
    chk("const_aw", {19'd0, axi.awlen, axi.awsize, axi.awburst, axi.awlock, axi.awcache, axi.awprot},
        {19'd0, 4'd0, 3'b010, 2'b01, 2'd0, 4'd0, 3'd0});
    chk("const_wlast", {31'd0, axi.wlast}, 32'd1);
    resetn = 1;
    tick();

    // Boot fetch at minimum latency.
    sb.push_back('{1'b0, 1'b0, 32'hBFC0_0000, 32'h3C08_0001});
    inst_en = 1; inst_addr = 32'hBFC0_0000;
    #1 chk("t1_stall_c0", {31'd0, inst_stall}, 32'd1);
    tick();
    chk("t1_arvalid_c1", {31'd0, axi.arvalid}, 32'd1);
    chk("t1_arid_c1", {28'd0, axi.arid}, 32'd0);
    chk("t1_araddr_c1", axi.araddr, 32'hBFC0_0000);
    chk("t1_stall_c1", {31'd0, inst_stall}, 32'd1);
    tick();
    chk("t1_rready_c2", {31'd0, axi.rready}, 32'd1);
    chk("t1_stall_c2", {31'd0, inst_stall}, 32'd1);
    tick();
    wait_done(1'b0, 1);
    inst_en = 0;
    tick();

    // Partial write, awready two cycles behind wready; inputs scrambled after latch.
    aw_delay = 2; w_delay = 0;
    sb.push_back('{1'b1, 1'b1, 32'h1FAF_0010, 32'h45F5_BEEF});
    data_en = 1; data_wen = 4'b0011; data_addr = 32'h1FAF_0010; data_wdata = 32'hDEAD_BEEF;
    tick();
    chk("t2_awvalid_c1", {31'd0, axi.awvalid}, 32'd1);
    chk("t2_wvalid_c1", {31'd0, axi.wvalid}, 32'd1);
    chk("t2_wstrb_c1", {28'd0, axi.wstrb}, 32'h3);
    chk("t2_awaddr_c1", axi.awaddr, 32'h1FAF_0010);
    chk("t2_wdata_c1", axi.wdata, 32'hDEAD_BEEF);
    chk("t2_ids_c1", {24'd0, axi.awid, axi.wid}, 32'h11);
    data_wen = 4'hF; data_addr = 32'h0; data_wdata = 32'h0;
    tick();
    chk("t2_wvalid_c2", {31'd0, axi.wvalid}, 32'd0);
    chk("t2_awvalid_c2", {31'd0, axi.awvalid}, 32'd1);
    chk("t2_wstrb_c2", {28'd0, axi.wstrb}, 32'h3);
    tick();
    chk("t2_awvalid_c3", {31'd0, axi.awvalid}, 32'd1);
    chk("t2_awaddr_c3", axi.awaddr, 32'h1FAF_0010);
    tick();
    chk("t2_awvalid_c4", {31'd0, axi.awvalid}, 32'd0);
    chk("t2_bready_c4", {31'd0, axi.bready}, 32'd1);
    chk("t2_stall_c4", {31'd0, data_stall}, 32'd1);
    tick();
    chk("t2_bready_c5", {31'd0, axi.bready}, 32'd0);
    wait_done(1'b1, 1);
    data_en = 0;
    tick();
    aw_delay = 0;
    do_read(1'b1, 32'h1FAF_0010, 32'h45F5_BEEF);

    // Simultaneous requests: data first, inst on the next IDLE.
    sb.push_back('{1'b1, 1'b0, 32'h0000_1000, 32'h5A5A_4A5A});
    sb.push_back('{1'b0, 1'b0, 32'hBFC0_0004, 32'hE59A_5A5E});
    data_en = 1; data_wen = 0; data_addr = 32'h0000_1000;
    inst_en = 1; inst_addr = 32'hBFC0_0004;
    tick();
    chk("t3_arid_first", {28'd0, axi.arid}, 32'd1);
    chk("t3_araddr_first", axi.araddr, 32'h0000_1000);
    chk("t3_inst_stall_c1", {31'd0, inst_stall}, 32'd1);
    wait_done(1'b1, 20);
    chk("t3_inst_stall_data_done", {31'd0, inst_stall}, 32'd1);
    data_en = 0;
    tick();
    chk("t3_inst_stall_idle", {31'd0, inst_stall}, 32'd1);
    tick();
    chk("t3_arid_second", {28'd0, axi.arid}, 32'd0);
    chk("t3_araddr_second", axi.araddr, 32'hBFC0_0004);
    wait_done(1'b0, 20);
    inst_en = 0;
    tick();

    // Flush while waiting for read data: transaction completes, no new AR.
    r_delay = 5;
    base_ar = ar_count;
    data_en = 1; data_wen = 0; data_addr = 32'h0000_2000;
    tick();
    tick();
    chk("t4_rready_c2", {31'd0, axi.rready}, 32'd1);
    data_en = 0;
    rr = 0; spurious = 0;
    for (int i = 0; i < 30; i++) begin
      if (axi.rready !== 1'b1) break;
      rr++;
      if (axi.arvalid !== 1'b0) spurious++;
      tick();
    end
    chk("t4_rready_cycles", rr, 32'd6);
    chk("t4_data_stall", {31'd0, data_stall}, 32'd0);
    chk("t4_rdata_captured", data_rdata, 32'h5A5A_7A5A);
    repeat (3) tick();
    chk("t4_no_arvalid", {31'd0, axi.arvalid}, 32'd0);
    chk("t4_ar_count", ar_count - base_ar, 32'd1);
    chk("t4_spurious", spurious, 32'd0);
    r_delay = 0;

    // Asynchronous reset while stuck in WR_REQ.
    aw_delay = 20; w_delay = 20;
    data_en = 1; data_wen = 4'hF; data_addr = 32'h0000_3000; data_wdata = 32'h1234_5678;
    tick();
    chk("t5_awvalid_c1", {31'd0, axi.awvalid}, 32'd1);
    tick();
    #2 resetn = 0;
    #1;
    chk("t5_rst_awvalid", {31'd0, axi.awvalid}, 32'd0);
    chk("t5_rst_wvalid", {31'd0, axi.wvalid}, 32'd0);
    chk("t5_rst_data_rdata", data_rdata, 32'd0);
    chk("t5_rst_inst_rdata", inst_rdata, 32'd0);
    chk("t5_rst_mem_untouched", peek(32'h0000_3000), 32'h5A5A_6A5A);
    data_en = 0;
    tick();
    tick();
    resetn = 1; aw_delay = 0; w_delay = 0;
    tick();
    do_write(32'h0000_3000, 4'hF, 32'h1234_5678, 32'h1234_5678);
    do_read(1'b1, 32'h0000_3000, 32'h1234_5678);

    // arready held low for 10 cycles.
    ar_delay = 10;
    sb.push_back('{1'b0, 1'b0, 32'hBFC0_0008, 32'hE59A_5A52});
    inst_en = 1; inst_addr = 32'hBFC0_0008;
    tick();
    n_ar = 0; addr_bad = 0; stall_bad = 0;
    for (int i = 0; i < 40; i++) begin
      if (axi.arvalid !== 1'b1) break;
      n_ar++;
      if (axi.araddr !== 32'hBFC0_0008) addr_bad++;
      if (inst_stall !== 1'b1) stall_bad++;
      tick();
    end
    chk("t6_arvalid_cycles", n_ar, 32'd11);
    chk("t6_araddr_stable", addr_bad, 32'd0);
    chk("t6_stall_held", stall_bad, 32'd0);
    wait_done(1'b0, 20);
    inst_en = 0; ar_delay = 0;
    tick();

    chk("sb_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cpu_axi_bridge.md
Name: cpu_axi_bridge

Overview:
- Sits directly downstream of the CPU top and converts its two SRAM-style ports into one AXI3 master:
  - instruction port: read-only;
  - data port: read/write.
- Returns per-port stall signals that drive the CPU's fetch and memory-stage stall-request inputs.
- One transaction is outstanding at a time. Every transfer is single-beat, 32-bit.
- No address translation is done here; the CPU top has already remapped the address.

Parameters:
INST_ID, 4'd0, AXI ID used for instruction reads
DATA_ID, 4'd1, AXI ID used for data reads and writes

Ports:
clk  in  1  clock; all logic on rising edge
resetn  in  1  asynchronous active-low reset
inst_sram_en  in  1  instruction read request
inst_sram_addr  in  32  instruction address
inst_sram_rdata  out  32  registered read data
inst_stall  out  1  fetch must hold
data_sram_en  in  1  data request
data_sram_wen  in  4  byte write enables; 0 means read
data_sram_addr  in  32  data address
data_sram_wdata  in  32  write data
data_sram_rdata  out  32  registered read data
data_stall  out  1  memory stage must hold
arid/araddr/arlen/arsize/arburst/arvalid  out  4/32/4/3/2/1  AXI read address
arready  in  1  AXI read address ready
rid/rdata/rresp/rlast/rvalid  in  4/32/2/1/1  AXI read data
rready  out  1  AXI read data ready
awid/awaddr/awlen/awsize/awburst/awvalid  out  4/32/4/3/2/1  AXI write address
awready  in  1  AXI write address ready
wid/wdata/wstrb/wlast/wvalid  out  4/32/4/1/1  AXI write data
wready  in  1  AXI write data ready
bid/bresp/bvalid  in  4/2/1  AXI write response
bready  out  1  AXI write response ready
arlock/arcache/arprot/awlock/awcache/awprot  out  2/4/3/2/4/3  tied to 0

Behaviour:
- Constant outputs:
  - arlen = awlen = 0, arsize = awsize = 3'b010, arburst = awburst = 2'b01, wlast = 1.
  - wid = awid.
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE.
- Reset (asynchronous): state = IDLE; both rdata registers = 0; latched request registers = 0; aw_done = w_done = 0; all valid/ready outputs = 0.
- Arbitration (IDLE only):
  - data_sram_en wins over inst_sram_en.
  - Data with wen != 0 goes to WR_REQ; data with wen == 0 goes to RD_ADDR; inst goes to RD_ADDR.
  - On exit from IDLE, latch source, addr, wen and wdata. Later input changes are ignored.
- RD_ADDR:
  - arvalid = 1; arid and araddr come from the latch.
  - Go to RD_DATA on arready.
  - arvalid and araddr stay stable until the handshake.
- RD_DATA:
  - rready = 1.
  - On rvalid, capture rdata into the source port's rdata register, then go to DONE.
  - rresp, rid and rlast are ignored.
- WR_REQ:
  - awvalid = ~aw_done and wvalid = ~w_done; wstrb = latched wen.
  - aw_done and w_done set independently on their handshakes.
  - Go to WR_RESP when both are complete; this includes both completing in the same cycle.
  - Clear aw_done and w_done on exit.
- WR_RESP: bready = 1; go to DONE on bvalid. bresp is ignored.
- DONE: one cycle, then IDLE.
- Stall rules (combinational):
  - port_stall = port_en & ~(state == DONE & latched source == port).
  - The non-served port keeps stalling while its en is high.
  - The rdata register holds its value until the next read for that port completes.
- Minimum latency with always-ready slave: a request seen in IDLE at cycle 0 gives stall = 1 for cycles 0–2 and stall = 0 with data valid in cycle 3. This holds for both reads and writes.
- CPU drops en mid-transaction (pipeline flush): the transaction still completes on AXI and the result is discarded. There is no abort.
- Simultaneous inst and data requests: data is served first and inst is served on the next IDLE. Back-to-back data requests can starve inst; this is accepted.
- Reset asserted mid-transaction: immediate return to IDLE with no AXI completion. The external interconnect is reset by the same resetn.

Test Plan:
- Inst read of 0xBFC00000 with slave arready = rvalid = 1, rdata = 0x3C080001 → arid = 0, araddr = 0xBFC00000 in cycle 1; inst_stall high cycles 0–2, low in cycle 3 with inst_sram_rdata = 0x3C080001.
- Data write of 0x1FAF0010, wen = 4'b0011, wdata = 0xDEADBEEF, with awready two cycles after wready → wstrb = 0011; awvalid and wvalid each drop after their own handshake; one bready cycle; data_stall low one cycle after bvalid.
- Inst and data both requesting in the same IDLE cycle → data transaction (arid = 1) issued first; inst_stall stays high until its own DONE; both rdata values are correct.
- data_sram_en drops while in RD_DATA with rvalid delayed 5 cycles → rready stays asserted, FSM reaches DONE then IDLE, no spurious new AR is issued.
- resetn pulsed low while in WR_REQ → outputs return to reset values asynchronously; after release a fresh request completes normally.
- Slave arready held low for 10 cycles → arvalid and araddr stay stable throughout; inst_stall stays high until DONE.
